// File: rtl/add_3.sv
// add_3: final adder of the quadratic evaluator, y = A + Bx + Cx^2.
// Two-stage elastic pipeline: S1 holds the exact 26-bit sum of three Q2.22
// terms; S2 holds the Q2.18 result after rounding (and optional clamping).
// Build option: define QUADRA_SAT_EN to clamp out-of-range results to the
// Q2.18 limits and count clamped results in sat_cnt; without it the result
// wraps and sat_flag/sat_cnt read zero.
module add_3 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      t0_fxd,
    input  logic [23:0]      t1_fxd,
    input  logic [23:0]      t2_fxd,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [19:0]      y_fxd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat_flag,
    output logic [CNT_W-1:0] sat_cnt
);

    // Round half up from Q.22 to Q.18: add half an output LSB, shift arithmetically.
    function automatic logic signed [21:0] round_q18(input logic signed [25:0] sum);
        return 22'((sum + 26'sd8) >>> 4);
    endfunction

`ifdef QUADRA_SAT_EN
    localparam logic signed [21:0] MAX_Q18 = 22'sd524287;
    localparam logic signed [21:0] MIN_Q18 = -22'sd524288;

    // Clamp to the 20-bit Q2.18 range; returns {clamped, value}.
    function automatic logic [20:0] clamp_q18(input logic signed [21:0] r);
        if (r > MAX_Q18)
            return {1'b1, 20'h7FFFF};
        else if (r < MIN_Q18)
            return {1'b1, 20'h80000};
        else
            return {1'b0, r[19:0]};
    endfunction
`endif

    logic                    s1_valid_q;
    logic                    s2_valid_q;
    logic signed [25:0]      s1_sum_q;
    logic signed [25:0]      s1_sum_d;
    logic [19:0]             y_q;
    logic [19:0]             y_d;
    logic                    sat_q;
    logic                    sat_d;
    logic                    s1_advance;
    logic                    in_fire;
    logic                    s2_load;

    assign s1_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s1_advance;
    assign in_fire    = in_valid && in_ready;
    assign s2_load    = s1_valid_q && s1_advance;

    // Next-state data: exact sign-extended sum into S1, rounded result into S2.
    always_comb begin
        s1_sum_d = $signed({{2{t0_fxd[23]}}, t0_fxd})
                 + $signed({{2{t1_fxd[23]}}, t1_fxd})
                 + $signed({{2{t2_fxd[23]}}, t2_fxd});
`ifdef QUADRA_SAT_EN
        {sat_d, y_d} = clamp_q18(round_q18(s1_sum_q));
`else
        sat_d = 1'b0;
        y_d   = 20'(round_q18(s1_sum_q));
`endif
    end

    // S1 data register: loads only on an accepted input, no reset needed.
    always_ff @(posedge clk) begin
        if (in_fire)
            s1_sum_q <= s1_sum_d;
    end

    // Stage valids and the visible result; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            sat_q      <= 1'b0;
        end else begin
            if (in_fire)
                s1_valid_q <= 1'b1;
            else if (s2_load)
                s1_valid_q <= 1'b0;

            if (s2_load) begin
                s2_valid_q <= 1'b1;
                y_q        <= y_d;
                sat_q      <= sat_d;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

`ifdef QUADRA_SAT_EN
    logic [CNT_W-1:0] sat_cnt_q;

    // Count clamped results as they are delivered; stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            sat_cnt_q <= '0;
        else if (s2_valid_q && out_ready && sat_q && (sat_cnt_q != '1))
            sat_cnt_q <= sat_cnt_q + CNT_W'(1);
    end

    assign sat_cnt  = sat_cnt_q;
    assign sat_flag = sat_q;
`else
    assign sat_cnt  = '0;
    assign sat_flag = sat_q;
`endif

    assign y_fxd     = y_q;
    assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_add_3.sv
// Scoreboard bench for add_3: stimulus pushes expected results computed from
// plain integer arithmetic; a monitor pops and compares on each output handshake.
module tb_add_3;
    localparam int CNT_W   = 2;
    localparam int MAX_CNT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [23:0]      t0_fxd, t1_fxd, t2_fxd;
    logic             in_valid;
    logic             in_ready;
    logic [19:0]      y_fxd;
    logic             out_valid;
    logic             out_ready;
    logic             sat_flag;
    logic [CNT_W-1:0] sat_cnt;

    always #5 clk = ~clk;

    add_3 #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .t0_fxd(t0_fxd), .t1_fxd(t1_fxd), .t2_fxd(t2_fxd),
        .in_valid(in_valid), .in_ready(in_ready),
        .y_fxd(y_fxd), .out_valid(out_valid), .out_ready(out_ready),
        .sat_flag(sat_flag), .sat_cnt(sat_cnt)
    );

    typedef struct {
        logic [19:0] y;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rdy_mode = 1'b0;
    bit   rdy_force = 1'b1;
    int   lowcnt;

`ifdef QUADRA_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: real-valued sum in Q.22 units, rounded half up to Q.18.
    function automatic exp_t model(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        exp_t e;
        int s;
        int r;
        s = int'($signed(a)) + int'($signed(b)) + int'($signed(c));
        r = (s + 8) >>> 4;
        if (SAT_EN && r > 524287) begin
            e.y = 20'h7FFFF; e.sat = 1'b1;
        end else if (SAT_EN && r < -524288) begin
            e.y = 20'h80000; e.sat = 1'b1;
        end else begin
            e.y = 20'(r); e.sat = 1'b0;
        end
        return e;
    endfunction

    // Downstream ready: random or forced, updated shortly after each edge.
    always @(posedge clk) begin
        #2;
        out_ready = rdy_mode ? ($urandom_range(0, 2) != 0) : rdy_force;
    end

    // Monitor: pops on each output handshake; checks stall stability and sat_cnt.
    bit          held = 1'b0;
    logic [19:0] held_y;
    logic        held_s;
    int          mcnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            held = 1'b0;
            mcnt = 0;
        end else begin
            check("sat_cnt", sat_cnt, mcnt);
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_y", y_fxd, held_y);
                check("stall_sat", sat_flag, held_s);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("y_fxd", y_fxd, e.y);
                    check("sat_flag", sat_flag, e.sat);
                    if (e.sat && mcnt < MAX_CNT) mcnt++;
                end
            end
            held   = out_valid && !out_ready;
            held_y = y_fxd;
            held_s = sat_flag;
        end
    end

    // Present one input and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        t0_fxd = a; t1_fxd = b; t2_fxd = c;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                sb.push_back(model(a, b, c));
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Single transaction into an empty pipe with out_ready high: result two cycles later.
    task automatic send_expect(input string name, input logic [23:0] a, input logic [23:0] b,
                               input logic [23:0] c, input logic [19:0] y, input logic s);
        send(a, b, c);
        @(negedge clk);
        check({name, "_early"}, out_valid, 0);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_y"}, y_fxd, y);
        check({name, "_sat"}, sat_flag, s);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        rdy_mode = 1'b0;
        rdy_force = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    function automatic logic [23:0] pick();
        case ($urandom_range(0, 7))
            0: return 24'h7FFFFF;
            1: return 24'h800000;
            2: return 24'h000000;
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        t0_fxd = 24'h100000; t1_fxd = 24'h0; t2_fxd = 24'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y_fxd, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);
        @(posedge clk); #1;

        send_expect("basic", 24'h100000, 24'h080000, 24'h000008, 20'h18001, 1'b0);
        drain();
        send_expect("neg_one", 24'hC00000, 24'h0, 24'h0, 20'hC0000, 1'b0);
        drain();
        send_expect("pos_max", 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
                    SAT_EN ? 20'h7FFFF : 20'h80000, SAT_EN);
        drain();
        check("pos_max_cnt", sat_cnt, SAT_EN ? 1 : 0);

        // Eight back-to-back inputs with a four-cycle downstream stall.
        lowcnt = 0;
        fork
            for (int i = 0; i < 8; i++) send(pick(), pick(), pick());
            begin
                repeat (3) @(posedge clk);
                #1 rdy_force = 1'b0;
                repeat (4) @(posedge clk);
                #1 rdy_force = 1'b1;
            end
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (!in_ready) lowcnt++;
            end
        join
        check("stall_in_ready_low", lowcnt > 0, 1);
        drain();

        // Reset with both stages full.
        rdy_force = 1'b0;
        @(posedge clk); #1;
        send(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        send(24'h800000, 24'h800000, 24'h800000);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_force = 1'b1;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_sat_cnt", sat_cnt, 0);
        check("flush_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send_expect("after_flush", 24'h100000, 24'h080000, 24'h000008, 20'h18001, 1'b0);
        drain();

        // Five consecutive clamped results against a 2-bit counter.
        for (int i = 0; i < 5; i++)
            send(i[0] ? 24'h800000 : 24'h7FFFFF, i[0] ? 24'h800000 : 24'h7FFFFF,
                 i[0] ? 24'h800000 : 24'h7FFFFF);
        drain();
        check("cnt_sticky", sat_cnt, SAT_EN ? 3 : 0);

        // Random traffic with random downstream backpressure.
        rdy_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(pick(), pick(), pick());
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        drain();
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
